mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Writeback stage between the EX/MEM pipeline register and the register file. It accepts one instruction per cycle from upstream and issues data-memory loads over a valid/response handshake, stalling upstream while a load is outstanding. It sign- or zero-extends load data and drives the register file's write port (`do_write_reg`, `do_reg_write`, `write_data`) from registered outputs. It also exposes a forwarding tap for the hazard logic.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles in LOAD_WAIT before the load is abandoned. Legal range is 2..255.
- `clk` in 1: single clock; all state updates on the posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: an instruction is present on the `ex_*` inputs.
- `ex_write_reg` in 5: destination register.
- `ex_reg_write` in 1: the instruction writes a register.
- `ex_mem_read` in 1: the instruction is a load.
- `ex_funct3` in 3: load width and sign selection.
- `ex_alu_result` in 32: ALU result, or the load address when `ex_mem_read` is high.
- `stall` out 1: upstream must hold the `ex_*` inputs stable while this is high.
- `dmem_req` out 1: load request; held high until the response arrives.
- `dmem_addr` out 32: word-aligned load address.
- `dmem_rvalid` in 1: load response valid.
- `dmem_rdata` in 32: load response word.
- `do_write_reg` out 5: register-file write index.
- `do_reg_write` out 1: register-file write enable, a one-cycle pulse per writeback.
- `write_data` out 32: register-file write data.
- `fwd_valid` out 1: forwarding tap enable.
- `fwd_reg` out 5: forwarding tap register index.
- `fwd_data` out 32: forwarding tap data.
- `bus_err` out 1: one-cycle pulse when a load times out.
- `misalign` out 1: one-cycle pulse when a load is misaligned; only present with `MISALIGN_TRAP_EN` defined, otherwise tied to 0.

## Operation
- States are IDLE and LOAD_WAIT.
- Reset drives state to IDLE. Every output and internal register resets to 0.
- **IDLE, `ex_valid`=1, `ex_mem_read`=0:**
  - Next cycle: `do_write_reg` = `ex_write_reg`, `write_data` = `ex_alu_result`.
  - `do_reg_write` = `ex_reg_write & (ex_write_reg != 0)`.
  - The stage stays in IDLE.
- **IDLE, `ex_valid`=1, `ex_mem_read`=1:**
  - Latch `write_reg`, `reg_write`, `funct3` and `addr[1:0]`.
  - Drive `dmem_addr` = `{ex_alu_result[31:2], 2'b00}`.
  - Go to LOAD_WAIT and clear the timeout counter.
  - `do_reg_write` is 0 in the following cycle.
- **LOAD_WAIT:**
  - `dmem_req`=1 and `stall`=1. Inputs are ignored.
  - The counter increments every cycle.
- **LOAD_WAIT, `dmem_rvalid`=1 sampled:**
  - Extract the result from `dmem_rdata` using the latched offset:
    - `funct3`=000 (lb): byte `[8*off +: 8]`, sign-extended.
    - `funct3`=100 (lbu): same byte, zero-extended.
    - `funct3`=001 (lh): halfword `[16*off[1] +: 16]`, sign-extended.
    - `funct3`=101 (lhu): same halfword, zero-extended.
    - `funct3`=010 and all other codes: the full word.
  - Register the result to `write_data` and pulse `do_reg_write` (x0 rule applies).
  - Return to IDLE.
- **LOAD_WAIT, counter = `TIMEOUT_CYCLES`-1, no `rvalid`:**
  - Return to IDLE and pulse `bus_err`.
  - No register write occurs.
- `rvalid` and timeout on the same edge: `rvalid` wins and `bus_err` stays 0.
- `dmem_rvalid` while in IDLE is ignored.
- `ex_valid`=0 in IDLE produces `do_reg_write`=0 next cycle.
- `fwd_valid`, `fwd_reg` and `fwd_data` equal `do_reg_write`, `do_write_reg` and `write_data`.
- Reset asserted mid-load returns the stage to IDLE immediately: `dmem_req`=0, `stall`=0, no write. A response arriving later is ignored.

## Timing
- Non-load latency: accepted at edge N, write visible in cycle N+1 and committed by the register file at edge N+2.
- Load path:
  - Accepted at edge N.
  - `dmem_req`/`stall` high from cycle N+1.
  - `rvalid` sampled at edge M, with M ≥ N+1.
  - Write pulse in cycle M+1.
  - `stall` low in cycle M+1; the next instruction is accepted at edge M+1.
- Throughput: one non-load per cycle. A load costs at least 2 cycles.
- `stall` is a registered function of state, with no combinational input-to-`stall` path.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A load with lh/lhu and `addr[0]`=1, or lw with `addr[1:0]`≠0, does not enter LOAD_WAIT.
  - `misalign` pulses the next cycle and no write occurs.
- `MISALIGN_TRAP_EN` undefined:
  - The offset bits the width cannot honour are forced to 0: lh uses `off[1]`, lw uses 0.
  - The load proceeds normally and `misalign` is constant 0.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs must be 0. Release, then feed an ALU op with x5 and 0x1234_5678: `do_reg_write`=1, `do_write_reg`=5, `write_data`=0x12345678 one cycle later.
- x0 suppression: ALU op with x0 and 0xFFFF_FFFF gives `do_reg_write`=0.
- Loads with `rdata`=0x80FF_7F01 and `rvalid` after 3 cycles:
  - lb at offset 1: 0x0000007F.
  - lb at offset 3: 0xFFFFFF80.
  - lhu at offset 2: 0x000080FF.
  - lw: 0x80FF7F01.
  - In each case `stall` is high for exactly 3 cycles.
- Timeout: with `TIMEOUT_CYCLES`=4 and no `rvalid`, `bus_err` pulses once after 4 LOAD_WAIT cycles with no write. A late `rvalid` is then ignored. A second run with `rvalid` on the 4th cycle writes with `bus_err`=0.
- Back-to-back: load then ALU op held under `stall`. The ALU write occurs exactly one cycle after the load write and `ex_*` is accepted once.
- Misalign: lw at address 0x102.
  - With the macro: `misalign`=1, `dmem_req` never asserted.
  - Without it: `dmem_addr`=0x100 and the full word is written.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Writeback stage: retires ALU results, runs one outstanding data-memory load, extends load data.
// Optional misaligned-load trap is enabled by defining MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    output logic        stall,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  do_write_reg,
    output logic        do_reg_write,
    output logic [31:0] write_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic {IDLE, LOAD_WAIT} state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  ld_reg_q;
    logic        ld_we_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_off_q;
    logic [31:0] dmem_addr_q;
    logic [4:0]  do_write_reg_q;
    logic        do_reg_write_q;
    logic [31:0] write_data_q;
    logic        bus_err_q;
    logic        misalign_q;

    logic [31:0] load_data_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        trap_hit;

`ifdef MISALIGN_TRAP_EN
    assign trap_hit = ex_mem_read &&
                      (((ex_funct3 == 3'b010) && (ex_alu_result[1:0] != 2'b00)) ||
                       ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]));
`else
    assign trap_hit = 1'b0;
`endif

    // Halfword select ignores off[0] and word select ignores off entirely, so
    // misaligned offsets degrade to the aligned container.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        load_data_d = dmem_rdata;
        ld_byte     = dmem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half     = dmem_rdata[{ld_off_q[1], 4'b0000} +: 16];
        case (ld_funct3_q)
            3'b000:  load_data_d = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data_d = {24'd0, ld_byte};
            3'b001:  load_data_d = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data_d = {16'd0, ld_half};
            default: load_data_d = dmem_rdata;
        endcase
    end

    // NOTE: all state here is small control/data registers, so every one is reset; non-blocking only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            ld_reg_q       <= 5'd0;
            ld_we_q        <= 1'b0;
            ld_funct3_q    <= 3'd0;
            ld_off_q       <= 2'd0;
            dmem_addr_q    <= 32'd0;
            do_write_reg_q <= 5'd0;
            do_reg_write_q <= 1'b0;
            write_data_q   <= 32'd0;
            bus_err_q      <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            do_reg_write_q <= 1'b0;
            bus_err_q      <= 1'b0;
            misalign_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (trap_hit) begin
                            misalign_q <= 1'b1;
                        end else if (ex_mem_read) begin
                            ld_reg_q    <= ex_write_reg;
                            ld_we_q     <= ex_reg_write;
                            ld_funct3_q <= ex_funct3;
                            ld_off_q    <= ex_alu_result[1:0];
                            dmem_addr_q <= {ex_alu_result[31:2], 2'b00};
                            cnt_q       <= 8'd0;
                            state_q     <= LOAD_WAIT;
                        end else begin
                            do_write_reg_q <= ex_write_reg;
                            write_data_q   <= ex_alu_result;
                            do_reg_write_q <= ex_reg_write && (ex_write_reg != 5'd0);
                        end
                    end
                end
                LOAD_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A response on the timeout edge still completes the load.
                    if (dmem_rvalid) begin
                        do_write_reg_q <= ld_reg_q;
                        write_data_q   <= load_data_d;
                        do_reg_write_q <= ld_we_q && (ld_reg_q != 5'd0);
                        state_q        <= IDLE;
                    end else if (cnt_q == LAST_CNT) begin
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall        = (state_q == LOAD_WAIT);
    assign dmem_req     = (state_q == LOAD_WAIT);
    assign dmem_addr    = dmem_addr_q;
    assign do_write_reg = do_write_reg_q;
    assign do_reg_write = do_reg_write_q;
    assign write_data   = write_data_q;
    assign fwd_valid    = do_reg_write_q;
    assign fwd_reg      = do_write_reg_q;
    assign fwd_data     = write_data_q;
    assign bus_err      = bus_err_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected writeback/error pulses with their
// cycle, a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_mem_wb_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic        stall;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  do_write_reg;
    logic        do_reg_write;
    logic [31:0] write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        bus_err;
    logic        misalign;

    mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .stall(stall), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .do_write_reg(do_write_reg), .do_reg_write(do_reg_write), .write_data(write_data),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // kind: 0 = register write, 1 = bus error, 2 = misalign trap
    typedef struct {
        int          kind;
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] w);
        int unsigned off, b, h;
        off = addr % 4;
        b   = (w >> (8 * off)) & 32'hFF;
        h   = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return ((f3 == 3'b010) && (addr % 4 != 0)) ||
               (((f3 == 3'b001) || (f3 == 3'b101)) && (addr % 2 != 0));
`else
        return 1'b0 && (f3 == 3'b000) && (addr == 32'd0);
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && (do_reg_write || bus_err || misalign)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, misalign, bus_err, do_reg_write}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {29'd0, misalign, bus_err, do_reg_write}, 32'(1 << mon_e.kind));
                check("pulse_cycle", cyc, mon_e.cyc);
                if (mon_e.kind == 0) begin
                    check("wb_reg", {27'd0, do_write_reg}, {27'd0, mon_e.rd});
                    check("wb_data", write_data, mon_e.data);
                    check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
                    check("fwd_reg", {27'd0, fwd_reg}, {27'd0, mon_e.rd});
                    check("fwd_data", fwd_data, mon_e.data);
                end
            end
        end
    end

    task automatic rand_ex();
        ex_valid      = 1'($urandom);
        ex_write_reg  = 5'($urandom);
        ex_reg_write  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_funct3     = 3'($urandom);
        ex_alu_result = $urandom;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data, input logic rw);
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b0;
        ex_write_reg  = rd;
        ex_reg_write  = rw;
        ex_funct3     = 3'($urandom);
        ex_alu_result = data;
        dmem_rvalid   = 1'($urandom);
        dmem_rdata    = $urandom;
        @(posedge clk); #1;
        if (rw && rd != 5'd0) exp_q.push_back('{0, cyc, rd, data});
        ex_valid    = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        if (!(rw && rd != 5'd0)) check("alu_no_write", {31'd0, do_reg_write}, 32'd0);
        check("alu_no_stall", {31'd0, stall}, 32'd0);
    endtask

    // rv: 0 = no response, 1 = stray response, 2 = random
    task automatic idle(input int n, input int rv);
        repeat (n) begin
            rand_ex();
            ex_valid    = 1'b0;
            dmem_rvalid = (rv == 1) ? 1'b1 : (rv == 2) ? 1'($urandom) : 1'b0;
            dmem_rdata  = $urandom;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            @(negedge clk);
            check("idle_no_write", {31'd0, do_reg_write}, 32'd0);
            check("idle_no_stall", {31'd0, stall}, 32'd0);
        end
    endtask

    task automatic load(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                        input logic [31:0] addr, input int delay, input logic [31:0] w,
                        input bit hold, input logic [4:0] hrd, input logic [31:0] hdata);
        bit wrote = 1'b0;
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_write_reg  = rd;
        ex_reg_write  = rw;
        ex_funct3     = f3;
        ex_alu_result = addr;
        dmem_rvalid   = 1'b0;
        @(posedge clk); #1;
        if (model_misaligned(f3, addr)) begin
            exp_q.push_back('{2, cyc, 5'd0, 32'd0});
            ex_valid = 1'b0;
            @(negedge clk);
            check("trap_no_req", {31'd0, dmem_req}, 32'd0);
            check("trap_no_stall", {31'd0, stall}, 32'd0);
            return;
        end
        ex_valid = 1'b0;
        for (int k = 1; k <= T + 8; k++) begin
            @(negedge clk);
            check("load_stall", {31'd0, stall}, 32'd1);
            check("load_req", {31'd0, dmem_req}, 32'd1);
            check("load_addr", dmem_addr, {addr[31:2], 2'b00});
            if (hold) begin
                ex_valid      = 1'b1;
                ex_mem_read   = 1'b0;
                ex_write_reg  = hrd;
                ex_reg_write  = 1'b1;
                ex_alu_result = hdata;
            end else begin
                rand_ex();
            end
            dmem_rvalid = (k == delay);
            dmem_rdata  = (k == delay) ? w : $urandom;
            @(posedge clk); #1;
            if (k == delay) begin
                if (rw && rd != 5'd0) begin
                    exp_q.push_back('{0, cyc, rd, model_load(f3, addr, w)});
                    wrote = 1'b1;
                end
                break;
            end
            if (k == T) begin
                exp_q.push_back('{1, cyc, 5'd0, 32'd0});
                break;
            end
        end
        dmem_rvalid = 1'b0;
        if (!hold) ex_valid = 1'b0;
        @(negedge clk);
        check("load_stall_release", {31'd0, stall}, 32'd0);
        check("load_req_release", {31'd0, dmem_req}, 32'd0);
        if (!wrote && delay <= T) check("load_no_write", {31'd0, do_reg_write}, 32'd0);
    endtask

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        rst_n       = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        rand_ex();

        repeat (4) begin
            @(negedge clk);
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_req", {31'd0, dmem_req}, 32'd0);
            check("rst_addr", dmem_addr, 32'd0);
            check("rst_wb", {26'd0, do_write_reg, do_reg_write}, 32'd0);
            check("rst_wdata", write_data, 32'd0);
            check("rst_fwd", {26'd0, fwd_reg, fwd_valid}, 32'd0);
            check("rst_fwd_data", fwd_data, 32'd0);
            check("rst_err", {30'd0, bus_err, misalign}, 32'd0);
            rand_ex();
            dmem_rvalid = 1'($urandom);
            dmem_rdata  = $urandom;
        end
        @(negedge clk);
        rst_n       = 1'b1;
        ex_valid    = 1'b0;
        dmem_rvalid = 1'b0;

        alu(5'd5, 32'h1234_5678, 1'b1);
        alu(5'd0, 32'hFFFF_FFFF, 1'b1);
        idle(1, 2);

        load(5'd7,  1'b1, 3'b000, 32'h0000_1001, 3, W, 1'b0, 5'd0, 32'd0);
        load(5'd8,  1'b1, 3'b000, 32'h0000_1003, 3, W, 1'b0, 5'd0, 32'd0);
        load(5'd9,  1'b1, 3'b101, 32'h0000_1002, 3, W, 1'b0, 5'd0, 32'd0);
        load(5'd10, 1'b1, 3'b010, 32'h0000_1000, 3, W, 1'b0, 5'd0, 32'd0);
        load(5'd0,  1'b1, 3'b010, 32'h0000_1000, 2, W, 1'b0, 5'd0, 32'd0);

        load(5'd11, 1'b1, 3'b010, 32'h0000_2000, T + 1, W, 1'b0, 5'd0, 32'd0);
        idle(2, 1);
        load(5'd12, 1'b1, 3'b010, 32'h0000_2000, T, W, 1'b0, 5'd0, 32'd0);

        load(5'd13, 1'b1, 3'b010, 32'h0000_3000, 2, W, 1'b1, 5'd14, 32'hCAFE_BABE);
        alu(5'd14, 32'hCAFE_BABE, 1'b1);
        idle(2, 0);

        load(5'd15, 1'b1, 3'b010, 32'h0000_0102, 2, W, 1'b0, 5'd0, 32'd0);
        idle(1, 0);

        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_write_reg  = 5'd9;
        ex_reg_write  = 1'b1;
        ex_funct3     = 3'b010;
        ex_alu_result = 32'h0000_0040;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("midrst_stall_before", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_write", {31'd0, do_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1);

        repeat (150) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                alu(5'($urandom), $urandom, $urandom_range(0, 3) != 0);
            end else if (sel == 4) begin
                idle(1, 2);
            end else begin
                logic [4:0]  hrd;
                logic [31:0] hdata;
                bit          hold;
                hrd   = 5'($urandom);
                hdata = $urandom;
                hold  = 1'($urandom);
                load(5'($urandom), $urandom_range(0, 3) != 0, 3'($urandom), $urandom,
                     $urandom_range(1, T + 2), $urandom, hold, hrd, hdata);
                if (hold) alu(hrd, hdata, 1'b1);
            end
        end

        idle(3, 0);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
